// File: rtl/p_mat_pkg.sv
// Shared types for the projection-matrix controller: datapath mode encodings,
// FSM states and memory-geometry helpers.
package p_mat_pkg;

  typedef enum logic [1:0] {
    ModeIdle = 2'd0,
    ModeMult = 2'd1,
    ModeNorm = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStream,
    StDrain1,
    StDrain2,
    StOut
  } state_e;

  // Two bands per coefficient word.
  function automatic int unsigned calc_words(input int unsigned bands);
    return bands / 2;
  endfunction

  // Two words per pixel beat, rounded up.
  function automatic int unsigned calc_beats(input int unsigned words);
    return (words + 1) / 2;
  endfunction

endpackage

// File: rtl/p_mat_ctrl_wrap_ctr.sv
// Modulo counter with synchronous clear, enable and a wrap flag that is high
// on the enabled cycle where the count returns to zero.
module wrap_ctr #(
  parameter int unsigned MODULO = 4,
  parameter int unsigned WIDTH  = (MODULO > 1) ? $clog2(MODULO) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = en && (count == WIDTH'(MODULO - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/p_mat_ctrl.sv
// Controller that loads the projection matrix and streams pixel beats into the
// norm datapath. Optional P_MAT_CTRL_PIXCNT_EN adds a 32-bit result counter.
module p_mat_ctrl
  import p_mat_pkg::*;
#(
  parameter int unsigned SPECTRAL_BANDS = 103,
  parameter int unsigned T_WIDTH        = 16,
  parameter int unsigned IN_I_WIDTH     = 16,
  parameter int unsigned IN_F_WIDTH     = 16,
  localparam int unsigned WORDS = calc_words(SPECTRAL_BANDS),
  localparam int unsigned BEATS = calc_beats(WORDS),
  localparam int unsigned PW    = IN_I_WIDTH + IN_F_WIDTH,
  localparam int unsigned RW    = $clog2(SPECTRAL_BANDS),
  localparam int unsigned CW    = $clog2(WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 coef_valid,
  output logic                 coef_ready,
  input  logic [2*T_WIDTH-1:0] coef_data,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [4*PW-1:0]      pix_data,
  output logic                 norm_valid,
  input  logic                 norm_ready,
  output logic [2*T_WIDTH-1:0] norm_out,
  output logic                 mat_loaded,
  output logic                 busy,
  output logic [RW-1:0]        row_1,
  output logic [RW-1:0]        row_2,
  output logic [CW-1:0]        col_1,
  output logic [CW-1:0]        col_2,
  output logic                 wr_en_1,
  output logic                 wr_en_2,
  output logic [2*T_WIDTH-1:0] in_1,
  output logic [2*T_WIDTH-1:0] in_2,
  output logic                 in_valid,
  output logic [4*PW-1:0]      in_pixel,
  output logic [1:0]           state,
  output logic                 mac_rst,
  input  logic [2*T_WIDTH-1:0] norm
`ifdef P_MAT_CTRL_PIXCNT_EN
  ,
  output logic [31:0]          pix_count
`endif
);

  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e state_q, state_d;
  mode_e  mode;

  logic                 mat_loaded_q, in_valid_q;
  logic [4*PW-1:0]      in_pixel_q, pix_next;
  logic [2*T_WIDTH-1:0] norm_q;
  logic                 coef_acc, pix_acc, cnt_clr;
  logic                 col_wrap, row_wrap, beat_wrap;
  logic [CW-1:0]        col_cnt;
  logic [RW-1:0]        row_cnt;
  logic [BW-1:0]        beat_cnt;

  assign coef_acc = coef_valid && coef_ready;
  assign pix_acc  = pix_valid && pix_ready;
  assign cnt_clr  = (state_q == StIdle);

  wrap_ctr #(.MODULO(WORDS), .WIDTH(CW)) u_col_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (coef_acc),
    .count (col_cnt),
    .wrap  (col_wrap)
  );

  wrap_ctr #(.MODULO(SPECTRAL_BANDS), .WIDTH(RW)) u_row_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (col_wrap),
    .count (row_cnt),
    .wrap  (row_wrap)
  );

  wrap_ctr #(.MODULO(BEATS), .WIDTH(BW)) u_beat_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (pix_acc),
    .count (beat_cnt),
    .wrap  (beat_wrap)
  );

  always_comb begin
    state_d    = state_q;
    coef_ready = 1'b0;
    pix_ready  = 1'b0;
    case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d = StLoad;
        end else if (mat_loaded_q && pix_valid) begin
          state_d = StStream;
        end
      end
      StLoad: begin
        coef_ready = 1'b1;
        if (row_wrap) state_d = StIdle;
      end
      StStream: begin
        pix_ready = 1'b1;
        if (beat_wrap) state_d = StDrain1;
      end
      StDrain1: state_d = StDrain2;
      StDrain2: state_d = StOut;
      StOut:    if (norm_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // With an odd word count the last beat's second word lies past the matrix.
  always_comb begin
    pix_next = pix_data;
    if (beat_wrap && (WORDS % 2 == 1)) pix_next[4*PW-1:2*PW] = '0;
  end

  always_comb begin
    mode = ModeIdle;
    case (state_q)
      StStream, StDrain1: mode = ModeMult;
      StDrain2, StOut:    mode = ModeNorm;
      default:            mode = ModeIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      mat_loaded_q <= 1'b0;
      in_valid_q   <= 1'b0;
      in_pixel_q   <= '0;
      norm_q       <= '0;
    end else begin
      state_q    <= state_d;
      in_valid_q <= pix_acc;
      if (pix_acc) in_pixel_q <= pix_next;
      if (state_q == StIdle && load_start) begin
        mat_loaded_q <= 1'b0;
      end else if (row_wrap) begin
        mat_loaded_q <= 1'b1;
      end
      if (state_q == StDrain2) norm_q <= norm;
    end
  end

`ifdef P_MAT_CTRL_PIXCNT_EN
  logic [31:0] pix_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_count_q <= '0;
    end else if (norm_valid && norm_ready) begin
      pix_count_q <= pix_count_q + 32'd1;
    end
  end

  assign pix_count = pix_count_q;
`endif

  assign wr_en_1    = coef_acc;
  assign wr_en_2    = 1'b0;
  assign in_1       = coef_acc ? coef_data : '0;
  assign in_2       = '0;
  assign row_1      = (state_q == StLoad) ? row_cnt : '0;
  assign row_2      = '0;
  assign col_1      = (state_q == StLoad)   ? col_cnt :
                      (state_q == StStream) ? CW'({beat_cnt, 1'b0}) : '0;
  assign col_2      = (state_q == StStream) ? CW'({beat_cnt, 1'b1}) : '0;
  assign in_valid   = in_valid_q;
  assign in_pixel   = in_pixel_q;
  assign norm_out   = norm_q;
  assign norm_valid = (state_q == StOut);
  assign mat_loaded = mat_loaded_q;
  assign busy       = (state_q != StIdle);
  assign state      = mode;
  assign mac_rst    = !(state_q == StStream || state_q == StDrain1);

endmodule

// File: tb/tb_p_mat_ctrl.sv
// Directed bench for p_mat_ctrl: matrix load, streaming with stalls and
// back-pressure, mid-stream reset and load/stream priority.
module tb_p_mat_ctrl;

  localparam int NWORDS = 51;
  localparam int NLOAD  = 103 * 51;
  localparam int NBEATS = 26;
  // Sum of band0 (1..26) plus band2 (100*(1..25)); last beat's band2 is dropped.
  localparam logic [31:0] EXP_NORM = 32'd32851;

  logic         clk = 1'b0;
  logic         rst, load_start, coef_valid, pix_valid, norm_ready;
  logic [31:0]  coef_data;
  logic [127:0] pix_data;
  logic         coef_ready, pix_ready, norm_valid, mat_loaded, busy;
  logic [31:0]  norm_out, in_1, in_2;
  logic [6:0]   row_1, row_2;
  logic [5:0]   col_1, col_2;
  logic         wr_en_1, wr_en_2, in_valid, mac_rst;
  logic [127:0] in_pixel;
  logic [1:0]   state;
  logic [31:0]  acc = 32'd0;

  p_mat_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_data  (coef_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .norm_valid (norm_valid),
    .norm_ready (norm_ready),
    .norm_out   (norm_out),
    .mat_loaded (mat_loaded),
    .busy       (busy),
    .row_1      (row_1),
    .row_2      (row_2),
    .col_1      (col_1),
    .col_2      (col_2),
    .wr_en_1    (wr_en_1),
    .wr_en_2    (wr_en_2),
    .in_1       (in_1),
    .in_2       (in_2),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .state      (state),
    .mac_rst    (mac_rst),
    .norm       (acc)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: accumulates band0 and band2 of each valid pixel.
  always @(posedge clk) begin
    if (mac_rst) acc <= 32'd0;
    else if (in_valid) acc <= acc + in_pixel[31:0] + in_pixel[95:64];
  end

  typedef struct {
    logic [127:0] pix;
    logic [5:0]   col1;
    logic [5:0]   col2;
    logic [127:0] exp_pix;
  } beat_t;

  beat_t        tab [NBEATS];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           wr_cnt, iv_cnt, acc_cyc, q;
  logic         wr2_seen = 1'b0;
  logic [6:0]   last_row;
  logic [5:0]   last_col;
  logic [127:0] iv_log [32];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en_2) wr2_seen = 1'b1;
    if (wr_en_1) begin
      q = wr_cnt;
      chk("wr_word", 128'({row_1, col_1, in_1}),
          128'({7'(q / NWORDS), 6'(q % NWORDS), 32'(((q / NWORDS) << 8) | (q % NWORDS))}));
      last_row = row_1;
      last_col = col_1;
      wr_cnt++;
    end
    if (in_valid) begin
      if (iv_cnt < 32) iv_log[iv_cnt] = in_pixel;
      iv_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    wr_cnt = 0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("load_enter", 128'({busy, mat_loaded, coef_ready}), 128'(3'b101));
    for (int i = 0; i < NLOAD; i++) begin
      if (i == 100) begin
        coef_valid = 1'b0;
        step();
        step();
      end
      if (i == NLOAD - 1) chk("load_not_done_yet", 128'(mat_loaded), 128'(0));
      coef_valid = 1'b1;
      coef_data  = 32'(((i / NWORDS) << 8) | (i % NWORDS));
      step();
    end
    coef_valid = 1'b0;
    chk("load_count", 128'(wr_cnt), 128'(NLOAD));
    chk("load_last_addr", 128'({last_row, last_col}), 128'({7'd102, 6'd50}));
    chk("load_done", 128'({busy, mat_loaded}), 128'(2'b01));
  endtask

  task automatic run_stream(input int stall_at, input int hold, input int ld_at,
                            input int rst_at);
    logic got, bad;
    iv_cnt = 0;
    for (int k = 0; k < NBEATS; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_stream", 128'({busy, state, mat_loaded, mac_rst, in_valid, norm_valid}),
            128'({1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
        return;
      end
      if (k == stall_at) begin
        pix_valid = 1'b0;
        bad = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          if (s > 0) bad |= in_valid;
          step();
        end
        chk("stall_no_in_valid", 128'(bad), 128'(0));
      end
      pix_valid  = 1'b1;
      pix_data   = tab[k].pix;
      load_start = (k == ld_at);
      got = 1'b0;
      for (int t = 0; t < 8 && !got; t++) begin
        @(negedge clk);
        if (pix_ready) begin
          got = 1'b1;
          chk("beat_cols", 128'({col_1, col_2}), 128'({tab[k].col1, tab[k].col2}));
          if (k == NBEATS - 1) acc_cyc = cyc;
        end
        step();
      end
      chk("beat_accepted", 128'(got), 128'(1));
      load_start = 1'b0;
      if (k == 1) chk("stream_mode", 128'({state, mac_rst, busy}), 128'({2'd1, 1'b0, 1'b1}));
    end
    pix_valid = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (norm_valid) begin
        got = 1'b1;
        chk("norm_latency", 128'(cyc - acc_cyc), 128'(3));
      end else begin
        step();
      end
    end
    chk("norm_seen", 128'(got), 128'(1));
    chk("norm_value", 128'(norm_out), 128'(EXP_NORM));
    chk("out_mode", 128'({state, mac_rst, pix_ready, coef_ready}),
        128'({2'd2, 1'b1, 1'b0, 1'b0}));
    chk("in_valid_count", 128'(iv_cnt), 128'(NBEATS));
    chk("last_pixel", iv_log[NBEATS-1], tab[NBEATS-1].exp_pix);
    chk("pixel_k10", iv_log[10], tab[10].exp_pix);
    if (hold > 0) begin
      bad = 1'b0;
      for (int h = 0; h < hold; h++) begin
        step();
        @(negedge clk);
        bad |= (norm_out != EXP_NORM) | pix_ready | coef_ready | !norm_valid;
      end
      chk("hold_stable", 128'(bad), 128'(0));
    end
    norm_ready = 1'b1;
    step();
    norm_ready = 1'b0;
    chk("out_to_idle", 128'({busy, norm_valid, state}), 128'(0));
    chk("still_loaded", 128'(mat_loaded), 128'(1));
  endtask

  initial begin
    logic bad;
    for (int k = 0; k < NBEATS; k++) begin
      logic [31:0] b0, b1, b2, b3;
      b0 = 32'(k + 1);
      b1 = 32'h1000_0000 + 32'(k);
      b2 = 32'(100 * (k + 1));
      b3 = 32'h2000_0000 + 32'(k);
      tab[k].pix     = {b3, b2, b1, b0};
      tab[k].col1    = 6'(2 * k);
      tab[k].col2    = 6'(2 * k + 1);
      tab[k].exp_pix = (k == NBEATS - 1) ? {64'd0, b1, b0} : {b3, b2, b1, b0};
    end

    rst = 1'b1; load_start = 1'b0; coef_valid = 1'b0; pix_valid = 1'b0; norm_ready = 1'b0;
    coef_data = '0; pix_data = '0; wr_cnt = 0; iv_cnt = 0; acc_cyc = 0;
    step();
    step();
    chk("reset_flags", 128'({mat_loaded, norm_valid, in_valid, wr_en_1, wr_en_2, busy,
                             coef_ready, pix_ready}), 128'(0));
    chk("reset_data", 128'({norm_out, in_pixel[31:0], row_1, col_1, col_2}), 128'(0));
    chk("reset_mode", 128'({mac_rst, state}), 128'({1'b1, 2'd0}));
    rst = 1'b0;

    pix_valid = 1'b1;
    step();
    step();
    chk("no_stream_unloaded", 128'({busy, pix_ready}), 128'(0));
    pix_valid = 1'b0;

    do_load();
    run_stream(-1, 20, -1, -1);
    run_stream(10, 0, 5, -1);
    run_stream(-1, 0, -1, 12);

    bad = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      bad |= busy | pix_ready | in_valid;
    end
    pix_valid = 1'b0;
    chk("no_stream_after_rst", 128'(bad), 128'(0));

    do_load();
    load_start = 1'b1;
    pix_valid  = 1'b1;
    @(negedge clk);
    chk("prio_idle_no_ready", 128'(pix_ready), 128'(0));
    step();
    load_start = 1'b0;
    chk("prio_load_wins", 128'({busy, mat_loaded, pix_ready, coef_ready}), 128'(4'b1001));
    pix_valid = 1'b0;
    chk("wr_en_2_never", 128'(wr2_seen), 128'(0));
    rst = 1'b1;
    step();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
